pulse_digit_counter: RTL
========================

PULSE_DIGIT_COUNTER -- requirements
Module: pulse_digit_counter

Interface
REQ-001 Parameter WINDOW_CYCLES, default 100000000, length of one counting window in clk cycles (minimum 8).
REQ-002 Parameter DEB_CYCLES, default 16, debounce stability length in clk cycles; used only when PDC_DEBOUNCE_EN is defined.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pulse_in  input  1  asynchronous raw heartbeat pulse from the sensor; one pulse per beat.
REQ-006 iden  output  1  digit-valid strobe; high for exactly one cycle per digit delivered on q_out.
REQ-007 q_out  output  4  BCD digit, 0-9, valid only while iden=1.
REQ-008 ovf  output  1  high while the digits being emitted belong to a saturated window.

Function
REQ-009 pulse_in SHALL pass through a 2-flop synchronizer, followed by a rising-edge detector producing a one-cycle beat event.
REQ-010 Window counter SHALL count 0..WINDOW_CYCLES-1 and wrap to 0; the cycle at WINDOW_CYCLES-1 is the terminal cycle.
REQ-011 Beat count SHALL be kept as three BCD digits (hundreds, tens, ones), incremented by 1 per beat event with decimal carry (9->0 and carry).
REQ-012 Count SHALL saturate at 999; a beat event at 999 SHALL hold 999 and set a sticky window-overflow bit.
REQ-013 On the terminal cycle the three digits and the overflow bit SHALL be copied to a snapshot register, then the accumulator and overflow bit SHALL be cleared for the next window.
REQ-014 A beat event in the terminal cycle SHALL be counted in the closing window (included in the snapshot).
REQ-015 Counting of the new window SHALL continue uninterrupted while the snapshot is being emitted.
REQ-016 FSM states: IDLE, EMIT_H, EMIT_T, EMIT_O; IDLE->EMIT_H on terminal cycle; EMIT_H->EMIT_T->EMIT_O->IDLE unconditionally, one cycle each.
REQ-017 In EMIT_H/EMIT_T/EMIT_O, iden=1 and q_out = snapshot hundreds/tens/ones respectively; in IDLE iden=0 and q_out=0.
REQ-018 First iden SHALL be high in the cycle immediately after the terminal cycle; digits on three consecutive cycles, hundreds first.
REQ-019 ovf SHALL equal the snapshot overflow bit during the three emit cycles and 0 in IDLE.
REQ-020 Leading zeros SHALL be emitted as digit 0 (always exactly three digits per window).
REQ-021 Since WINDOW_CYCLES >= 8, a new terminal cycle can never occur during emission; no back-pressure exists.

Reset
REQ-022 While rst=1: iden=0, q_out=0, ovf=0, FSM=IDLE, window counter=0, accumulator=000, snapshot=000, overflow bits=0, synchronizer and edge-detect flops=0.
REQ-023 rst asserted mid-emission SHALL abort emission on the next edge; remaining digits of that window are never output.
REQ-024 After rst deasserts, the first window SHALL be a full WINDOW_CYCLES long, starting at counter 0.
REQ-025 A pulse_in already high when rst deasserts SHALL NOT produce a beat event until it goes low then high.

Configuration
REQ-026 Macro PDC_DEBOUNCE_EN: when defined, the synchronized input SHALL only change its filtered value after remaining stable for DEB_CYCLES consecutive cycles, and the edge detector SHALL use the filtered value (adds DEB_CYCLES cycles of latency).
REQ-027 Without PDC_DEBOUNCE_EN, the edge detector SHALL use the synchronized input directly and DEB_CYCLES is unused.

Verification (WINDOW_CYCLES=2000, DEB_CYCLES=4 unless stated)
REQ-028 5 clean pulses (10 cycles high, 10 low) in first window -> after terminal cycle iden on 3 cycles with q_out 0,0,5, ovf=0.
REQ-029 127 pulses (3 high/3 low, WINDOW_CYCLES=1000, debounce off) -> q_out 1,2,7; next window with 0 pulses -> 0,0,0.
REQ-030 1005 pulses in one window (WINDOW_CYCLES=8000, debounce off) -> q_out 9,9,9 with ovf=1 on all three strobes; following window with 3 pulses -> 0,0,3, ovf=0.
REQ-031 Pulse edge landing exactly on the terminal cycle -> counted in closing window (snapshot +1), new window starts at 000.
REQ-032 rst pulsed for 1 cycle during EMIT_T -> no further iden, outputs 0, next emission only after a full new window.
REQ-033 PDC_DEBOUNCE_EN defined: 2-cycle glitches x10 plus 3 clean 20-cycle pulses -> q_out 0,0,3; without macro same stimulus -> 0,1,3.

Source files
------------

// File: rtl/pulse_digit_counter.sv
// pulse_digit_counter: counts heartbeat pulses per fixed window as three BCD
// digits, then emits hundreds/tens/ones on q_out with a one-cycle iden strobe.
// Build option: define PDC_DEBOUNCE_EN to insert a stability filter of
// DEB_CYCLES cycles between the synchronizer and the edge detector.
module pulse_digit_counter #(
  parameter int unsigned WINDOW_CYCLES = 100000000,
  parameter int unsigned DEB_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  output logic       iden,
  output logic [3:0] q_out,
  output logic       ovf
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_H = 2'd1,
    EMIT_T = 2'd2,
    EMIT_O = 2'd3
  } state_t;

  logic             sync_meta;
  logic             sync_q;
  logic [1:0]       fill;
  logic             level;
  logic             level_q;
  logic             armed;
  logic             beat;
  logic [WIN_W-1:0] win_cnt;
  logic             terminal;
  logic [3:0]       acc_h, acc_t, acc_o;
  logic             acc_ovf;
  logic [3:0]       inc_h, inc_t, inc_o;
  logic             inc_ovf;
  logic [3:0]       snap_t, snap_o;
  logic             snap_ovf;
  state_t           state_q, state_d;
  logic             iden_d;
  logic [3:0]       q_d;
  logic             ovf_d;

  // Two-flop synchronizer; fill marks when sync_q carries a real post-reset sample
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      fill      <= 2'b00;
    end else begin
      sync_meta <= pulse_in;
      sync_q    <= sync_meta;
      fill      <= {fill[0], 1'b1};
    end
  end

`ifdef PDC_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt;
  logic             filt;

  // Filtered level follows sync_q only after it has differed for DEB_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      filt    <= 1'b0;
    end else if (sync_q == filt) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      filt    <= sync_q;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign level = filt;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES == 0);
  assign level = sync_q;
`endif

  // Rising-edge detector; armed only once the real input was seen low after reset,
  // so an input already high at reset release is not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_q <= level;
      if (fill[1] && !sync_q) armed <= 1'b1;
    end
  end

  assign beat = level & ~level_q & armed;

  // Free-running window counter, wraps after the terminal cycle
  always_ff @(posedge clk) begin
    if (rst || terminal) win_cnt <= '0;
    else                 win_cnt <= win_cnt + WIN_W'(1);
  end

  assign terminal = (win_cnt == WIN_LAST);

  // Saturating BCD increment of the accumulator by the current beat
  always_comb begin
    inc_h   = acc_h;
    inc_t   = acc_t;
    inc_o   = acc_o;
    inc_ovf = acc_ovf;
    if (beat) begin
      if (acc_h == 4'd9 && acc_t == 4'd9 && acc_o == 4'd9) begin
        inc_ovf = 1'b1;
      end else if (acc_o != 4'd9) begin
        inc_o = acc_o + 4'd1;
      end else begin
        inc_o = 4'd0;
        if (acc_t != 4'd9) begin
          inc_t = acc_t + 4'd1;
        end else begin
          inc_t = 4'd0;
          inc_h = acc_h + 4'd1;
        end
      end
    end
  end

  // Accumulate; on the terminal cycle capture the closing count (incl. its beat) and restart
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_h    <= 4'd0;
      acc_t    <= 4'd0;
      acc_o    <= 4'd0;
      acc_ovf  <= 1'b0;
      snap_t   <= 4'd0;
      snap_o   <= 4'd0;
      snap_ovf <= 1'b0;
    end else if (terminal) begin
      acc_h    <= 4'd0;
      acc_t    <= 4'd0;
      acc_o    <= 4'd0;
      acc_ovf  <= 1'b0;
      snap_t   <= inc_t;
      snap_o   <= inc_o;
      snap_ovf <= inc_ovf;
    end else begin
      acc_h    <= inc_h;
      acc_t    <= inc_t;
      acc_o    <= inc_o;
      acc_ovf  <= inc_ovf;
    end
  end

  // Emission FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and next outputs; the hundreds digit goes straight to the output
  // register from the increment path, so it needs no snapshot copy
  always_comb begin
    state_d = state_q;
    iden_d  = 1'b0;
    q_d     = 4'd0;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (terminal) begin
          state_d = EMIT_H;
          iden_d  = 1'b1;
          q_d     = inc_h;
          ovf_d   = inc_ovf;
        end
      end
      EMIT_H: begin
        state_d = EMIT_T;
        iden_d  = 1'b1;
        q_d     = snap_t;
        ovf_d   = snap_ovf;
      end
      EMIT_T: begin
        state_d = EMIT_O;
        iden_d  = 1'b1;
        q_d     = snap_o;
        ovf_d   = snap_ovf;
      end
      EMIT_O: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      iden  <= 1'b0;
      q_out <= 4'd0;
      ovf   <= 1'b0;
    end else begin
      iden  <= iden_d;
      q_out <= q_d;
      ovf   <= ovf_d;
    end
  end

endmodule
